string_fetch_master: RTL and testbench
======================================

STRING_FETCH_MASTER -- requirements
Module: string_fetch_master

Interface
REQ-001 Parameter ADDR_W, default 32, Avalon-MM master byte-address width.
REQ-002 Parameter FIFO_DEPTH, default 16, output FIFO entries; power of two, 4..64.
REQ-003 Parameter LEN_W, default 8, width of word_count.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  one-cycle request to begin a fetch; sampled only in IDLE.
REQ-007 Port base_addr  input  ADDR_W  first word byte address, 4-byte aligned; captured on accepted start.
REQ-008 Port word_count  input  LEN_W  number of 32-bit words to fetch; captured on accepted start.
REQ-009 Port busy  output  1  high in every state except IDLE.
REQ-010 Port done  output  1  one-cycle pulse at fetch completion.
REQ-011 Port avm_address  output  ADDR_W  read address.
REQ-012 Port avm_read  output  1  read request.
REQ-013 Port avm_waitrequest  input  1  slave stall; request held while high.
REQ-014 Port avm_readdata  input  32  read response data.
REQ-015 Port avm_readdatavalid  input  1  response strobe; in-order, one per accepted read.
REQ-016 Port out_data  output  32  FIFO head word.
REQ-017 Port out_valid  output  1  FIFO non-empty.
REQ-018 Port out_ready  input  1  consumer pop; pop occurs when out_valid && out_ready.
REQ-019 Port null_found  output  1  terminator detected (see Configuration).

Function
REQ-020 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-021 IDLE: start=1 with word_count>0 -> ISSUE; start=1 with word_count=0 -> DONE; no read issued.
REQ-022 ISSUE: avm_read=1 while words_left>0 and (fifo_count + outstanding) < FIFO_DEPTH.
REQ-023 A read is accepted when avm_read && !avm_waitrequest; then avm_address += 4, words_left -= 1, outstanding += 1.
REQ-024 avm_address and avm_read held stable while avm_waitrequest=1; no request withdrawn once asserted.
REQ-025 First avm_read asserted the cycle after start is accepted.
REQ-026 ISSUE -> DRAIN when words_left reaches 0; DRAIN -> DONE when outstanding=0 and no response pending in that cycle.
REQ-027 Each avm_readdatavalid pushes avm_readdata into FIFO and decrements outstanding; accept and response in same cycle leave outstanding unchanged.
REQ-028 Credit rule guarantees no FIFO overflow; a push when full is a design error flagged by assertion.
REQ-029 FIFO has no bypass: word pushed in cycle N visible on out_data in cycle N+1; simultaneous push and pop allowed at any fill level.
REQ-030 DONE lasts one cycle, done=1, then -> IDLE; FIFO contents remain drainable after done.
REQ-031 start while busy is ignored; avm_readdatavalid in IDLE is discarded.
REQ-032 avm_address wraps modulo 2^ADDR_W.

Reset
REQ-033 On reset: state IDLE, busy=0, done=0, avm_read=0, avm_address=0, outstanding=0, words_left=0, FIFO empty (out_valid=0, out_data=0), null_found=0.
REQ-034 Reset mid-fetch abandons all outstanding reads; subsequent stale responses are discarded per REQ-031.

Configuration
REQ-035 Macro STRING_FETCH_NULL_STOP_EN defined: a response word with any zero byte lane is pushed, null_found is set (sticky until next accepted start), words_left is cleared, later responses are discarded, FSM goes to DRAIN.
REQ-036 Macro undefined: null_found tied 0; all word_count words fetched and pushed regardless of content.

Structure
REQ-037 Package string_hw_pkg holds the FSM state enum, WORD_W=32, and ADDR_STEP=4.
REQ-038 FIFO is sub-module string_fifo (sync, parameterised depth, count output).

Verification
REQ-039 base=0x1000, count=3, zero-wait slave -> reads at 0x1000/0x1004/0x1008 in 3 consecutive cycles, 3 words out in order, one done pulse.
REQ-040 waitrequest high 5 cycles on second read -> avm_address stays 0x1004, avm_read stays 1, no duplicate or lost word.
REQ-041 count=40, FIFO_DEPTH=16, out_ready=0 -> exactly 16 reads accepted then avm_read=0; raising out_ready resumes and all 40 words delivered.
REQ-042 count=0 -> done pulse 2 cycles after start, avm_read never asserted.
REQ-043 Reset asserted with 4 outstanding, then late readdatavalid -> FIFO stays empty, busy=0.
REQ-044 With STRING_FETCH_NULL_STOP_EN, second word 0x41420043, count=8 -> 2 words output, null_found=1, done pulse after outstanding reaches 0.

Source files
------------

// File: rtl/string_hw_pkg.sv
// Shared types and constants for the string fetch master.
package string_hw_pkg;

  localparam int WORD_W    = 32;
  localparam int ADDR_STEP = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fsm_state_e;

  // A word terminates the string when any of its byte lanes is zero.
  function automatic logic has_zero_byte(input logic [WORD_W-1:0] w);
    return (w[7:0] == 8'h00) || (w[15:8] == 8'h00) ||
           (w[23:16] == 8'h00) || (w[31:24] == 8'h00);
  endfunction

endpackage

// File: rtl/string_fifo.sv
// Synchronous FIFO with occupancy count; write data visible one cycle after push.
module string_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic [W-1:0]   data_i,
  input  logic           pop_i,
  output logic [W-1:0]   data_o,
  output logic           valid_o,
  output logic [PTR_W:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      if (push_i && !do_pop)      cnt_q <= cnt_q + (PTR_W+1)'(1);
      else if (!push_i && do_pop) cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

  // The master's credit scheme must never push into a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (rst)
    !(push_i && (cnt_q == (PTR_W+1)'(DEPTH)) && !do_pop));

endmodule

// File: rtl/string_fetch_master.sv
// Avalon-MM read master: fetches word_count words from base_addr into an output FIFO.
// Optional STRING_FETCH_NULL_STOP_EN stops the fetch at the first word holding a zero byte.
module string_fetch_master
  import string_hw_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [WORD_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              null_found
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fsm_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W+1:0]  credit;
  logic              read_q, null_q, drop_q;
  logic              accept, rsp, push, pop, hit_null, stalled, can_issue;

  assign accept  = read_q && !avm_waitrequest;
  assign stalled = read_q && avm_waitrequest;
  assign rsp     = avm_readdatavalid && (state_q != IDLE) && (outst_q != '0);
  assign push    = rsp && !drop_q;
  assign pop     = out_valid && out_ready;

`ifdef STRING_FETCH_NULL_STOP_EN
  assign hit_null = rsp && !drop_q && has_zero_byte(avm_readdata);
`else
  assign hit_null = 1'b0;
`endif

  always_comb begin
    words_left_d = words_left_q;
    if (hit_null)                           words_left_d = '0;
    else if (accept && words_left_q != '0)  words_left_d = words_left_q - LEN_W'(1);
    outst_d = outst_q;
    if (accept && !rsp)      outst_d = outst_q + CNT_W'(1);
    else if (!accept && rsp) outst_d = outst_q - CNT_W'(1);
  end

  // Slots already committed next cycle: words held in the FIFO plus reads in flight.
  assign credit = (CNT_W+2)'(fifo_count) + (CNT_W+2)'(outst_q)
                + (CNT_W+2)'(accept) - (CNT_W+2)'(pop);
  assign can_issue = (words_left_d != '0) && (credit < (CNT_W+2)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      outst_q      <= '0;
      read_q       <= 1'b0;
      null_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      words_left_q <= words_left_d;
      outst_q      <= outst_d;
      if (accept) addr_q <= addr_q + ADDR_W'(ADDR_STEP);
      if (hit_null) begin
        null_q <= 1'b1;
        drop_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          read_q <= 1'b0;
          if (start) begin
            addr_q       <= base_addr;
            words_left_q <= word_count;
            null_q       <= 1'b0;
            drop_q       <= 1'b0;
            read_q       <= (word_count != '0);
            state_q      <= (word_count != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          // A stalled request is held even if the fetch was cut short meanwhile.
          if (stalled) begin
            read_q <= 1'b1;
          end else begin
            read_q <= can_issue;
            if (words_left_d == '0) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          read_q <= 1'b0;
          if (outst_q == '0 && !avm_readdatavalid) state_q <= DONE;
        end
        default: begin
          read_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  string_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .data_i  (avm_readdata),
    .pop_i   (pop),
    .data_o  (out_data),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign null_found  = null_q;

endmodule

// File: tb/tb_string_fetch_master.sv
// Self-checking bench for string_fetch_master: slave model, output scoreboard, vector table.
module tb_string_fetch_master;

  logic        clk = 1'b0;
  logic        reset, start, avm_waitrequest, avm_readdatavalid, out_ready;
  logic [31:0] base_addr, avm_readdata, avm_address, out_data;
  logic [7:0]  word_count;
  logic        busy, done, avm_read, out_valid, null_found;

  string_fetch_master dut (
    .clk (clk), .reset (reset), .start (start), .base_addr (base_addr),
    .word_count (word_count), .busy (busy), .done (done),
    .avm_address (avm_address), .avm_read (avm_read),
    .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid), .out_data (out_data),
    .out_valid (out_valid), .out_ready (out_ready), .null_found (null_found)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_acc = 0, done_cnt = 0, n_out = 0, first_acc = 0, last_acc = 0;
  logic [31:0] exp_addr, stall_addr, last_addr, null_addr;
  int  stall_left = 0;
  bit  rsp_hold = 0, consume_en = 1, wait_r = 0, null_mode = 0, read_seen = 0;
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (null_mode && a == null_addr) return 32'h41420043;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) cyc++;

  // Slave: decides waitrequest for the coming edge, returns data one cycle after accept.
  always @(negedge clk) begin
    if (reset) begin
      wait_r = 0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
    end else begin
      if (!rsp_hold && pend_q.size() > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = data_of(pend_q.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
      end
      if (wait_r) begin
        check("stall_read_held", {31'd0, avm_read}, 32'd1);
        check("stall_addr_held", avm_address, last_addr);
      end
      if (avm_read && avm_address == stall_addr && stall_left > 0) begin
        wait_r = 1;
        stall_left--;
      end else begin
        wait_r = 0;
      end
      avm_waitrequest = wait_r;
      if (avm_read) read_seen = 1;
      if (avm_read && !wait_r) begin
        pend_q.push_back(avm_address);
        check("read_addr", avm_address, exp_addr);
        exp_addr = exp_addr + 32'd4;
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
      end
      last_addr = avm_address;
    end
  end

  // Consumer and scoreboard.
  always @(negedge clk) begin
    out_ready = consume_en;
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("unexpected_out", out_data, 32'hxxxx_xxxx);
      else                   check("out_data", out_data, exp_q.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic launch(input logic [31:0] base, input int count, input int n_exp);
    @(negedge clk);
    n_acc = 0; done_cnt = 0; n_out = 0; read_seen = 0;
    exp_addr = base;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(data_of(base + 32'(4 * i)));
    base_addr = base; word_count = 8'(count); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    for (int i = 0; i < budget && !(done_cnt > 0 && exp_q.size() == 0 && !out_valid); i++)
      @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] base;
    int          count;
    logic [31:0] stall_addr;
    int          stall_cyc;
    int          exp_span;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'h0000_1000, 3, 32'h0000_0001, 0, 2};
    vecs[1] = '{32'h0000_1000, 3, 32'h0000_1004, 5, 7};
    vecs[2] = '{32'h0000_2000, 7, 32'h0000_2008, 2, 8};
    vecs[3] = '{32'hFFFF_FFF8, 4, 32'h0000_0000, 3, 6};

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; out_ready = 1'b1;
    stall_addr = 32'h1; null_addr = 32'h1; last_addr = '0; exp_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", avm_address, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_null", {31'd0, null_found}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      stall_addr = vecs[v].stall_addr;
      stall_left = vecs[v].stall_cyc;
      launch(vecs[v].base, vecs[v].count, vecs[v].count);
      check("first_read_next_cycle", {31'd0, avm_read}, 32'd1);
      wait_finish(200);
      check("reads_accepted", n_acc, vecs[v].count);
      check("words_out", n_out, vecs[v].count);
      check("read_span", last_acc - first_acc, vecs[v].exp_span);
      check("done_pulses", done_cnt, 1);
      check("busy_after", {31'd0, busy}, 32'd0);
      check("sb_empty", exp_q.size(), 0);
      check("null_clear", {31'd0, null_found}, 32'd0);
    end

    // Back-pressure: credit limit stops issue at FIFO depth.
    stall_left = 0;
    consume_en = 0;
    launch(32'h0000_5000, 40, 40);
    repeat (40) @(negedge clk);
    check("bp_reads_capped", n_acc, 16);
    check("bp_read_low", {31'd0, avm_read}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    consume_en = 1;
    wait_finish(400);
    check("bp_reads_all", n_acc, 40);
    check("bp_words_out", n_out, 40);
    check("bp_done", done_cnt, 1);
    check("bp_sb_empty", exp_q.size(), 0);

    // Zero-length fetch.
    launch(32'h0000_6000, 0, 0);
    repeat (4) @(negedge clk);
    check("zero_done", done_cnt, 1);
    check("zero_no_read", {31'd0, read_seen}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);

    // Reset with four reads outstanding, then stale responses.
    rsp_hold = 1;
    stall_addr = 32'h0000_3010;
    stall_left = 1000;
    launch(32'h0000_3000, 8, 8);
    for (int i = 0; i < 50 && n_acc < 4; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rst_outstanding", n_acc, 4);
    reset = 1'b1;
    exp_q.delete();
    stall_left = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rsp_hold = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stale_fifo_empty", {31'd0, out_valid}, 32'd0);
    end
    check("stale_all_returned", pend_q.size(), 0);
    check("stale_busy", {31'd0, busy}, 32'd0);
    check("stale_no_out", n_out, 0);

`ifdef STRING_FETCH_NULL_STOP_EN
    null_mode = 1;
    null_addr = 32'h0000_4004;
    launch(32'h0000_4000, 8, 2);
    wait_finish(200);
    repeat (4) @(negedge clk);
    check("null_words_out", n_out, 2);
    check("null_found", {31'd0, null_found}, 32'd1);
    check("null_done", done_cnt, 1);
    check("null_sb_empty", exp_q.size(), 0);
    null_mode = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
